// File: rtl/antirrebote_pkg.sv
`default_nettype none
// ============================================================================
// Module   : antirrebote_pkg
// Purpose  : Shared types and default parameters for the multi-channel
//            debouncer (antirrebote_multi / antirrebote_canal).
// Contents : ab_estado_t  - per-channel debounce state
//            *_DEF        - default values for the top-level parameters
// Revision : 1.0 - initial release
// ============================================================================
package antirrebote_pkg;

  // The encoding is chosen so that bit [1] equals the debounced level:
  // EST_0/ESP_1 -> 0, EST_1/ESP_0 -> 1.
  typedef enum logic [1:0] {
    EST_0 = 2'd0,
    ESP_1 = 2'd1,
    EST_1 = 2'd2,
    ESP_0 = 2'd3
  } ab_estado_t;

  localparam int N_CH_DEF      = 8;
  localparam int TICK_DIV_DEF  = 512;
  localparam int N_CONFIRM_DEF = 3;

endpackage
`default_nettype wire

// File: rtl/antirrebote_canal.sv
`default_nettype none
// ============================================================================
// Module   : antirrebote_canal
// Purpose  : One debounce channel: 2-flop synchroniser, 4-state confirm FSM,
//            confirm counter and registered rise/fall pulses.
// Ports    : clk    in  system clock
//            rst    in  synchronous active-high reset
//            sw     in  raw asynchronous input
//            tick   in  shared prescaler tick (one clk wide)
//            salida out debounced level (registered)
//            rise   out one-cycle pulse, coincident with salida 0->1
//            fall   out one-cycle pulse, coincident with salida 1->0
// Revision : 1.0 - initial release
// ============================================================================
module antirrebote_canal
  import antirrebote_pkg::*;
#(
  parameter int N_CONFIRM = N_CONFIRM_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  input  logic tick,
  output logic salida,
  output logic rise,
  output logic fall
);

  localparam int              CW       = $clog2(N_CONFIRM + 1);
  localparam logic [CW-1:0]   CTR_LAST = CW'(N_CONFIRM - 1);

  logic          s1;
  logic          s2;
  ab_estado_t    estado;
  logic [CW-1:0] ctr;

  // Input revert is checked before the tick, so a bounce landing on the
  // final tick cancels the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      estado <= EST_0;
      ctr    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= sw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      case (estado)
        EST_0: begin
          if (s2) begin
            estado <= ESP_1;
            ctr    <= '0;
          end
        end
        ESP_1: begin
          if (!s2) begin
            estado <= EST_0;
          end else if (tick) begin
            if (ctr == CTR_LAST) begin
              estado <= EST_1;
              rise   <= 1'b1;
            end else begin
              ctr <= ctr + 1'b1;
            end
          end
        end
        EST_1: begin
          if (!s2) begin
            estado <= ESP_0;
            ctr    <= '0;
          end
        end
        ESP_0: begin
          if (s2) begin
            estado <= EST_1;
          end else if (tick) begin
            if (ctr == CTR_LAST) begin
              estado <= EST_0;
              fall   <= 1'b1;
            end else begin
              ctr <= ctr + 1'b1;
            end
          end
        end
        default: estado <= EST_0;
      endcase
    end
  end

  // Level comes straight from a state flop (see encoding in the package).
  assign salida = estado[1];

endmodule
`default_nettype wire

// File: rtl/antirrebote_multi.sv
`default_nettype none
// ============================================================================
// Module   : antirrebote_multi
// Purpose  : Parametrised multi-channel debouncer with shared tick prescaler,
//            sticky event flags and aggregate interrupt.
// Ports    : clk_i        in  1     system clock
//            reset_i      in  1     synchronous active-high reset
//            sw_i         in  N_CH  raw asynchronous inputs
//            clr_evento_i in  N_CH  per-channel clear of evento_o
//            salida_o     out N_CH  debounced levels
//            rise_o       out N_CH  one-cycle rise pulses
//            fall_o       out N_CH  one-cycle fall pulses
//            evento_o     out N_CH  sticky event flags
//            irq_o        out 1     OR of evento_o
// Revision : 1.0 - initial release
// ============================================================================
module antirrebote_multi
  import antirrebote_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int N_CONFIRM = N_CONFIRM_DEF
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [N_CH-1:0] sw_i,
  input  logic [N_CH-1:0] clr_evento_i,
  output logic [N_CH-1:0] salida_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] evento_o,
  output logic            irq_o
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]   pre;
  logic            tick;
  logic [N_CH-1:0] evento;

  // Free-running prescaler; count==0 right after reset, so the first tick
  // is in the first cycle following reset release.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pre <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = (pre == '0);

  for (genvar g = 0; g < N_CH; g++) begin : g_canal
    antirrebote_canal #(
      .N_CONFIRM (N_CONFIRM)
    ) u_canal (
      .clk    (clk_i),
      .rst    (reset_i),
      .sw     (sw_i[g]),
      .tick   (tick),
      .salida (salida_o[g]),
      .rise   (rise_o[g]),
      .fall   (fall_o[g])
    );
  end

  // Set has priority over clear so a coincident event is never lost.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      evento <= '0;
    end else begin
      evento <= (evento & ~clr_evento_i) | rise_o | fall_o;
    end
  end

  assign evento_o = evento;
  assign irq_o    = |evento;

endmodule
`default_nettype wire

// File: tb/tb_antirrebote_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_antirrebote_multi
// Purpose  : Self-checking bench for antirrebote_multi (N_CH=2, TICK_DIV=4,
//            N_CONFIRM=3). Expected rise/fall pulses with their cycle windows
//            are queued by the stimulus and matched by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_antirrebote_multi;

  localparam int NCH = 2;
  localparam int TD  = 4;
  localparam int NC  = 3;
  // Window measured from the drive point (just after a posedge): the input is
  // sampled at the next edge, then 3+(NC-1)*TD .. 2+NC*TD further edges.
  localparam int WLO = 1 + 3 + (NC - 1) * TD;
  localparam int WHI = 1 + 2 + NC * TD;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] sw;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] salida_o;
  logic [NCH-1:0] rise_o;
  logic [NCH-1:0] fall_o;
  logic [NCH-1:0] evento_o;
  logic           irq_o;

  antirrebote_multi #(
    .N_CH      (NCH),
    .TICK_DIV  (TD),
    .N_CONFIRM (NC)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .sw_i         (sw),
    .clr_evento_i (clr),
    .salida_o     (salida_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .evento_o     (evento_o),
    .irq_o        (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    int ch;
    bit rise;
    int lo;
    int hi;
  } sb_t;

  sb_t sb_q[$];

  task automatic push_req(input int ch, input bit is_rise);
    sb_t e;
    e.ch   = ch;
    e.rise = is_rise;
    e.lo   = cyc + WLO;
    e.hi   = cyc + WHI;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  bit [NCH-1:0] prev_p;
  bit [NCH-1:0] pend_ev;

  always @(negedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (pend_ev[ch]) begin
          pend_ev[ch] = 1'b0;
          ncmp++;
          if (!(evento_o[ch] && irq_o)) begin
            nerr++;
            $display("FAIL evento_after_pulse ch%0d: evento=%0b irq=%0b, required 1/1", ch, evento_o[ch], irq_o);
          end
        end
        if (rise_o[ch] || fall_o[ch]) begin
          ncmp++;
          if (prev_p[ch]) begin
            nerr++;
            $display("FAIL pulse_width ch%0d: pulse still high at cyc %0d, required 1 cycle", ch, cyc);
          end else if (sb_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_pulse ch%0d: rise=%0b fall=%0b at cyc %0d, required none", ch, rise_o[ch], fall_o[ch], cyc);
          end else begin
            sb_t e;
            e = sb_q.pop_front();
            if (e.ch != ch || e.rise != rise_o[ch] || fall_o[ch] == rise_o[ch] ||
                cyc < e.lo || cyc > e.hi || salida_o[ch] != rise_o[ch]) begin
              nerr++;
              $display("FAIL pulse_match: got ch%0d rise=%0b fall=%0b salida=%0b cyc=%0d, required ch%0d rise=%0b cyc %0d..%0d",
                       ch, rise_o[ch], fall_o[ch], salida_o[ch], cyc, e.ch, e.rise, e.lo, e.hi);
            end
          end
          pend_ev[ch] = 1'b1;
        end
        prev_p[ch] = rise_o[ch] | fall_o[ch];
      end
      if (sb_q.size() > 0 && cyc > sb_q[0].hi) begin
        ncmp++;
        nerr++;
        $display("FAIL pulse_timeout: ch%0d rise=%0b not seen by cyc %0d, required by %0d", sb_q[0].ch, sb_q[0].rise, cyc, sb_q[0].hi);
        void'(sb_q.pop_front());
      end
    end else begin
      prev_p  = '0;
      pend_ev = '0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    rst = 1'b1;
    sw  = 2'b11;
    clr = 2'b00;

    // Reset with inputs high: everything stays at 0.
    step(3);
    @(negedge clk);
    chk("reset_salida", 32'(salida_o), 32'h0);
    chk("reset_rise",   32'(rise_o),   32'h0);
    chk("reset_fall",   32'(fall_o),   32'h0);
    chk("reset_evento", 32'(evento_o), 32'h0);
    chk("reset_irq",    32'(irq_o),    32'h0);

    // Release: both channels rise within the window.
    step(1);
    rst = 1'b0;
    push_req(0, 1'b1);
    push_req(1, 1'b1);
    step(20);
    @(negedge clk);
    chk("release_salida", 32'(salida_o), 32'h3);
    chk("release_evento", 32'(evento_o), 32'h3);
    chk("release_irq",    32'(irq_o),    32'h1);

    // Second reset with inputs low to start from a clean state.
    step(1);
    rst = 1'b1;
    sw  = 2'b00;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset2_salida", 32'(salida_o), 32'h0);
    chk("reset2_evento", 32'(evento_o), 32'h0);
    chk("reset2_irq",    32'(irq_o),    32'h0);
    step(5);

    // Glitch on ch0 (6 cycles) is rejected.
    sw[0] = 1'b1;
    step(6);
    sw[0] = 1'b0;
    step(20);
    @(negedge clk);
    chk("glitch_salida0", 32'(salida_o[0]), 32'h0);
    chk("glitch_evento0", 32'(evento_o[0]), 32'h0);
    chk("glitch_irq",     32'(irq_o),       32'h0);

    // Bounce on ch1: 5 toggles 3 cycles apart, ending high.
    step(1);
    for (int i = 0; i < 5; i++) begin
      sw[1] = ~sw[1];
      if (i < 4) step(3);
    end
    push_req(1, 1'b1);
    step(20);
    @(negedge clk);
    chk("bounce_salida1", 32'(salida_o[1]), 32'h1);
    chk("bounce_evento1", 32'(evento_o[1]), 32'h1);
    chk("bounce_irq",     32'(irq_o),       32'h1);

    // Release ch1 and collide a clear with the fall pulse.
    step(1);
    sw[1] = 1'b0;
    push_req(1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 25 && !seen; i++) begin
      @(negedge clk);
      if (fall_o[1]) seen = 1'b1;
    end
    chk("fall1_seen", 32'(seen), 32'h1);
    clr = 2'b10;
    step(1);
    @(negedge clk);
    chk("collision_evento1", 32'(evento_o[1]), 32'h1);
    step(1);
    clr = 2'b00;
    @(negedge clk);
    chk("clear_evento1", 32'(evento_o[1]), 32'h0);
    chk("clear_irq",     32'(irq_o),       32'h0);
    chk("fall_salida1",  32'(salida_o[1]), 32'h0);

    // Reset while ch0 waits with ctr==2: no rise, wait restarts.
    step(1);
    sw[0] = 1'b1;
    step(11);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    push_req(0, 1'b1);
    @(negedge clk);
    chk("midwait_salida", 32'(salida_o), 32'h0);
    chk("midwait_rise0",  32'(rise_o[0]), 32'h0);
    step(20);
    @(negedge clk);
    chk("midwait_final_salida0", 32'(salida_o[0]), 32'h1);

    step(5);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
